// File: rtl/snake_pkg.sv
// snake_pkg: shared constants and the body-store state encoding for the
// snake body arbiter and its round-robin sub-arbiter.
package snake_pkg;

  // Playfield and body geometry
  localparam int XSIZE    = 48;
  localparam int YSIZE    = 64;
  localparam int COORD_W  = 6;
  localparam int MAX_SIZE = 20;
  localparam int LEN_W    = $clog2(MAX_SIZE + 1);

  // Read requester slots
  localparam int N_RD    = 3;
  localparam int RD_VGA  = 0;
  localparam int RD_COL  = 1;
  localparam int RD_ITEM = 2;

  // Body store service state
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/snake_rr_arbiter.sv
// snake_rr_arbiter: 3-way one-hot read arbiter with a registered pointer.
// The pointer moves to just past the last winner.
// Optional macro SNAKE_ARB_VGA_PRIO_EN: the VGA slot always wins when it
// requests; the collision and item slots share the round-robin between them.
module snake_rr_arbiter
  import snake_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_En,
  input  logic [2:0] i_Req,
  output logic [2:0] o_Gnt
);

  logic [1:0] r_Ptr;
  logic [1:0] w_Ptr_Nxt;
  logic [2:0] w_Gnt;

`ifdef SNAKE_ARB_VGA_PRIO_EN
  // VGA first; between collision and item, r_Ptr == RD_ITEM favours item
  always_comb begin
    w_Gnt     = '0;
    w_Ptr_Nxt = r_Ptr;
    if (i_En) begin
      if (i_Req[RD_VGA]) begin
        w_Gnt[RD_VGA] = 1'b1;
      end else if (i_Req[RD_COL] && (r_Ptr != 2'(RD_ITEM) || !i_Req[RD_ITEM])) begin
        w_Gnt[RD_COL] = 1'b1;
        w_Ptr_Nxt     = 2'(RD_ITEM);
      end else if (i_Req[RD_ITEM]) begin
        w_Gnt[RD_ITEM] = 1'b1;
        w_Ptr_Nxt      = 2'(RD_VGA);
      end
    end
  end
`else
  logic [2:0] w_Cand;
  logic       w_Found;

  // Scan requesters starting at the pointer, first requester found wins
  always_comb begin
    w_Gnt     = '0;
    w_Ptr_Nxt = r_Ptr;
    w_Cand    = '0;
    w_Found   = 1'b0;
    if (i_En) begin
      for (int k = 0; k < N_RD; k++) begin
        w_Cand = {1'b0, r_Ptr} + 3'(k);
        if (w_Cand > 3'd2) w_Cand = w_Cand - 3'd3;
        if (!w_Found && i_Req[w_Cand[1:0]]) begin
          w_Found              = 1'b1;
          w_Gnt[w_Cand[1:0]]   = 1'b1;
          w_Ptr_Nxt            = (w_Cand[1:0] == 2'd2) ? 2'd0 : w_Cand[1:0] + 2'd1;
        end
      end
    end
  end
`endif

  // Pointer register, starts at requester 0
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) r_Ptr <= 2'd0;
    else        r_Ptr <= w_Ptr_Nxt;
  end

  assign o_Gnt = w_Gnt;

endmodule

// File: rtl/snake_body_arbiter.sv
// snake_body_arbiter: owns the circular snake body store (index 0 = head)
// and shares it between the game move/grow port and three cell readers.
// Optional macro SNAKE_ARB_VGA_PRIO_EN (inside snake_rr_arbiter) gives the
// VGA reader fixed priority over the other readers.
//
// Handshakes:
//   move: o_Mv_Ack is combinational in the cycle i_Mv_Req is accepted; the
//         new head and o_Len are visible from the next cycle.
//   read: a requester holds i_Rd_Req[r] and its index until o_Rd_Gnt[r]
//         (combinational, same cycle); o_Rd_Vld[r] with X/Y/Oob follows one
//         cycle later for exactly one cycle. A move or i_Clr blocks grants.
module snake_body_arbiter
  import snake_pkg::state_t;
  import snake_pkg::CLEAR;
  import snake_pkg::READY;
  import snake_pkg::N_RD;
#(
  parameter int MAX_SIZE = snake_pkg::MAX_SIZE,
  parameter int COORD_W  = snake_pkg::COORD_W,
  parameter int LEN_W    = $clog2(MAX_SIZE + 1)
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_Clr,
  input  logic                 i_Mv_Req,
  input  logic                 i_Mv_Grow,
  input  logic [COORD_W-1:0]   i_Mv_X,
  input  logic [COORD_W-1:0]   i_Mv_Y,
  output logic                 o_Mv_Ack,
  input  logic [2:0]           i_Rd_Req,
  input  logic [3*LEN_W-1:0]   i_Rd_Idx,
  output logic [2:0]           o_Rd_Gnt,
  output logic [2:0]           o_Rd_Vld,
  output logic [COORD_W-1:0]   o_Rd_X,
  output logic [COORD_W-1:0]   o_Rd_Y,
  output logic                 o_Rd_Oob,
  output logic [LEN_W-1:0]     o_Len,
  output logic                 o_Busy,
  output logic                 o_Dbg_State
);

  localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_SIZE);
  localparam logic [LEN_W-1:0] MAX_M1 = LEN_W'(MAX_SIZE - 1);

  state_t                 r_State;
  state_t                 w_State_Nxt;
  logic [LEN_W-1:0]       r_Clr_Cnt;
  logic [LEN_W-1:0]       r_Head;
  logic [LEN_W-1:0]       r_Len;
  logic [2*COORD_W-1:0]   r_Mem [MAX_SIZE];

  logic [2:0]             r_Rd_Vld;
  logic [COORD_W-1:0]     r_Rd_X;
  logic [COORD_W-1:0]     r_Rd_Y;
  logic                   r_Rd_Oob;

  logic                   w_Ready;
  logic                   w_Last_Clr;
  logic                   w_Mv_Ack;
  logic                   w_Arb_En;
  logic [2:0]             w_Gnt;
  logic [LEN_W-1:0]       w_Head_Nxt;
  logic [LEN_W-1:0]       w_Len_Nxt;
  logic [LEN_W-1:0]       w_Rd_Idx;
  logic [LEN_W:0]         w_Rd_Sum;
  logic [LEN_W-1:0]       w_Rd_Addr;
  logic                   w_Rd_Oob;
  logic                   w_We;
  logic [LEN_W-1:0]       w_Waddr;
  logic [2*COORD_W-1:0]   w_Wdata;

  assign w_Ready    = (r_State == READY);
  assign w_Last_Clr = (r_State == CLEAR) && (r_Clr_Cnt == MAX_M1);
  // Moves win over reads; i_Clr suppresses both in the cycle it arrives
  assign w_Mv_Ack   = i_Rst && w_Ready && i_Mv_Req && !i_Clr;
  assign w_Arb_En   = i_Rst && w_Ready && !i_Mv_Req && !i_Clr;

  snake_rr_arbiter u_arb (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .i_En  (w_Arb_En),
    .i_Req (i_Rd_Req),
    .o_Gnt (w_Gnt)
  );

  // Next state: i_Clr always restarts the sweep, sweep ends after last cell
  always_comb begin
    w_State_Nxt = r_State;
    if (i_Clr) begin
      w_State_Nxt = CLEAR;
    end else begin
      case (r_State)
        CLEAR:   if (w_Last_Clr) w_State_Nxt = READY;
        READY:   w_State_Nxt = READY;
        default: w_State_Nxt = CLEAR;
      endcase
    end
  end

  // State, sweep counter, head pointer and length registers
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      r_State   <= CLEAR;
      r_Clr_Cnt <= '0;
      r_Head    <= '0;
      r_Len     <= '0;
    end else begin
      r_State <= w_State_Nxt;
      if (i_Clr) begin
        r_Clr_Cnt <= '0;
      end else if (r_State == CLEAR) begin
        if (w_Last_Clr) begin
          r_Clr_Cnt <= '0;
          r_Head    <= '0;
          r_Len     <= '0;
        end else begin
          r_Clr_Cnt <= r_Clr_Cnt + 1'b1;
        end
      end else if (w_Mv_Ack) begin
        r_Head <= w_Head_Nxt;
        r_Len  <= w_Len_Nxt;
      end
    end
  end

  // Head moves back one slot (wrapping); length grows until saturation
  always_comb begin
    w_Head_Nxt = (r_Head == '0) ? MAX_M1 : r_Head - 1'b1;
    w_Len_Nxt  = r_Len;
    if (r_Len == '0)                           w_Len_Nxt = LEN_W'(1);
    else if (i_Mv_Grow && (r_Len < MAX_L))     w_Len_Nxt = r_Len + 1'b1;
  end

  // Granted index to physical address; out-of-range indices read slot 0
  always_comb begin
    w_Rd_Idx = '0;
    for (int r = 0; r < N_RD; r++) begin
      if (w_Gnt[r]) w_Rd_Idx = i_Rd_Idx[r*LEN_W +: LEN_W];
    end
    w_Rd_Oob = (w_Rd_Idx >= r_Len);
    w_Rd_Sum = {1'b0, r_Head} + {1'b0, w_Rd_Idx};
    if (w_Rd_Oob)                       w_Rd_Addr = '0;
    else if (w_Rd_Sum >= {1'b0, MAX_L}) w_Rd_Addr = LEN_W'(w_Rd_Sum - {1'b0, MAX_L});
    else                                w_Rd_Addr = w_Rd_Sum[LEN_W-1:0];
  end

  // Single write port: sweep zeros while clearing, new head on a move
  always_comb begin
    w_We    = 1'b0;
    w_Waddr = r_Clr_Cnt;
    w_Wdata = '0;
    if (i_Rst && (r_State == CLEAR)) begin
      w_We = 1'b1;
    end else if (w_Mv_Ack) begin
      w_We    = 1'b1;
      w_Waddr = w_Head_Nxt;
      w_Wdata = {i_Mv_X, i_Mv_Y};
    end
  end

  // Body store write
  always_ff @(posedge i_Clk) begin
    if (w_We) r_Mem[w_Waddr] <= w_Wdata;
  end

  // Registered read data, zero whenever nothing valid is returned
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      r_Rd_Vld <= '0;
      r_Rd_X   <= '0;
      r_Rd_Y   <= '0;
      r_Rd_Oob <= 1'b0;
    end else begin
      r_Rd_Vld <= w_Gnt;
      r_Rd_Oob <= (w_Gnt != '0) && w_Rd_Oob;
      if ((w_Gnt != '0) && !w_Rd_Oob) begin
        {r_Rd_X, r_Rd_Y} <= r_Mem[w_Rd_Addr];
      end else begin
        r_Rd_X <= '0;
        r_Rd_Y <= '0;
      end
    end
  end

  assign o_Mv_Ack    = w_Mv_Ack;
  assign o_Rd_Gnt    = w_Gnt;
  assign o_Rd_Vld    = r_Rd_Vld;
  assign o_Rd_X      = r_Rd_X;
  assign o_Rd_Y      = r_Rd_Y;
  assign o_Rd_Oob    = r_Rd_Oob;
  assign o_Len       = r_Len;
  assign o_Busy      = (r_State == CLEAR);
  assign o_Dbg_State = r_State;

endmodule

// File: tb/tb_snake_body_arbiter.sv
// tb_snake_body_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-based body model.
module tb_snake_body_arbiter;

  localparam int MS = 20;
  localparam int CW = 6;
  localparam int LW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n   = 1'b0;
  logic            clr     = 1'b0;
  logic            mv_req  = 1'b0;
  logic            mv_grow = 1'b0;
  logic [CW-1:0]   mv_x    = '0;
  logic [CW-1:0]   mv_y    = '0;
  logic [2:0]      rd_req  = '0;
  logic [3*LW-1:0] rd_idx  = '0;

  logic            o_mv_ack;
  logic [2:0]      o_rd_gnt;
  logic [2:0]      o_rd_vld;
  logic [CW-1:0]   o_rd_x;
  logic [CW-1:0]   o_rd_y;
  logic            o_rd_oob;
  logic [LW-1:0]   o_len;
  logic            o_busy;
  logic            o_dbg_state;

  snake_body_arbiter dut (
    .i_Clk       (clk),
    .i_Rst       (rst_n),
    .i_Clr       (clr),
    .i_Mv_Req    (mv_req),
    .i_Mv_Grow   (mv_grow),
    .i_Mv_X      (mv_x),
    .i_Mv_Y      (mv_y),
    .o_Mv_Ack    (o_mv_ack),
    .i_Rd_Req    (rd_req),
    .i_Rd_Idx    (rd_idx),
    .o_Rd_Gnt    (o_rd_gnt),
    .o_Rd_Vld    (o_rd_vld),
    .o_Rd_X      (o_rd_x),
    .o_Rd_Y      (o_rd_y),
    .o_Rd_Oob    (o_rd_oob),
    .o_Len       (o_len),
    .o_Busy      (o_busy),
    .o_Dbg_State (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Body kept head-first in a queue; clear modelled as cycles remaining.
  logic [2*CW-1:0] body_q[$];
  int              m_left   = MS;
  int              m_len    = 0;
  int              m_last   = 2;
  int              m_last12 = 2;
  logic [2:0]      m_vld    = '0;
  logic [CW-1:0]   m_x      = '0;
  logic [CW-1:0]   m_y      = '0;
  logic            m_oob    = 1'b0;
  logic            started  = 1'b0;
  logic [2:0]      g_prev   = '0;

  function automatic logic [2:0] pick(input logic [2:0] req);
    logic [2:0] g;
    g = '0;
`ifdef SNAKE_ARB_VGA_PRIO_EN
    if (req[0])                    g[0] = 1'b1;
    else if (req[1] && req[2])     g[(m_last12 == 1) ? 2 : 1] = 1'b1;
    else if (req[1])               g[1] = 1'b1;
    else if (req[2])               g[2] = 1'b1;
`else
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (m_last + k) % 3;
      if (req[c] && g == '0) g[c] = 1'b1;
    end
`endif
    return g;
  endfunction

  task automatic model_step();
    logic       ready;
    logic       e_ack;
    logic [2:0] e_gnt;
    int         r;
    int         idx;
    ready = rst_n && (m_left == 0);
    e_ack = ready && mv_req && !clr;
    e_gnt = (ready && !mv_req && !clr) ? pick(rd_req) : 3'b000;

    check("mv_ack", o_mv_ack, e_ack);
    check("rd_gnt", o_rd_gnt, e_gnt);
    check("rd_vld", o_rd_vld, m_vld);
    check("rd_x",   o_rd_x,   m_x);
    check("rd_y",   o_rd_y,   m_y);
    check("rd_oob", o_rd_oob, m_oob);
    check("len",    o_len,    m_len);
    check("busy",   o_busy,   m_left > 0);
    check("state",  o_dbg_state, m_left == 0);
    g_prev = o_rd_gnt;

    if (!rst_n) begin
      m_left = MS; m_len = 0; body_q.delete();
      m_last = 2; m_last12 = 2;
      m_vld = '0; m_x = '0; m_y = '0; m_oob = 1'b0;
    end else begin
      m_vld = e_gnt; m_x = '0; m_y = '0; m_oob = 1'b0;
      if (e_gnt != '0) begin
        r   = e_gnt[0] ? 0 : (e_gnt[1] ? 1 : 2);
        idx = int'(rd_idx[r*LW +: LW]);
        if (idx >= m_len) m_oob = 1'b1;
        else {m_x, m_y} = body_q[idx];
        m_last = r;
        if (r != 0) m_last12 = r;
      end
      if (clr) begin
        m_left = MS;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin m_len = 0; body_q.delete(); end
      end else if (e_ack) begin
        body_q.push_front({mv_x, mv_y});
        if (m_len == 0)                 m_len = 1;
        else if (mv_grow && m_len < MS) m_len++;
        while (body_q.size() > m_len) void'(body_q.pop_back());
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 100) begin n++; @(negedge clk); end
    check(name, n, MS);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; mv_req = 1'b0; mv_grow = 1'b0; rd_req = '0;
    tick(); tick();
    rst_n = 1'b1;
    wait_clear("busy_after_reset");
  endtask

  task automatic mv(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic grow);
    mv_req = 1'b1; mv_x = x; mv_y = y; mv_grow = grow;
    @(negedge clk);
    check("mv_ack_directed", o_mv_ack, 1);
    @(posedge clk); #1;
    mv_req = 1'b0; mv_grow = 1'b0;
  endtask

  task automatic rd(input int r, input int idx, output logic [CW-1:0] x,
                    output logic [CW-1:0] y, output logic oob);
    int          n;
    logic [31:0] iv;
    iv = idx;
    n  = 0;
    rd_idx[r*LW +: LW] = iv[LW-1:0];
    rd_req[r] = 1'b1;
    @(negedge clk);
    while (!o_rd_gnt[r] && n < 50) begin n++; @(negedge clk); end
    check("rd_granted", o_rd_gnt[r], 1);
    @(posedge clk); #1;
    rd_req[r] = 1'b0;
    @(negedge clk);
    check("rd_vld_directed", o_rd_vld[r], 1);
    x = o_rd_x; y = o_rd_y; oob = o_rd_oob;
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] rr_exp [6];

  initial begin
    logic [CW-1:0] x, y;
    logic          oob;
    logic [2:0]    pend;
    int            n, g, got;

`ifdef SNAKE_ARB_VGA_PRIO_EN
    rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`else
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`endif

    // Reset and initial clear sweep
    @(posedge clk);
    started = 1'b1;
    #1;
    tick(); tick();
    rst_n = 1'b1;
    wait_clear("busy_after_reset");
    @(negedge clk);
    check("len_after_reset", o_len, 0);
    tick();
    rd(0, 0, x, y, oob);
    check("empty_rd_oob", oob, 1);
    check("empty_rd_x", x, 0);
    check("empty_rd_y", y, 0);

    // Two grows and a plain move
    mv(6'd24, 6'd32, 1'b1);
    mv(6'd25, 6'd32, 1'b1);
    mv(6'd26, 6'd32, 1'b0);
    @(negedge clk);
    check("len_after_3_moves", o_len, 2);
    tick();
    rd(1, 0, x, y, oob);
    check("idx0_x", x, 26); check("idx0_y", y, 32); check("idx0_oob", oob, 0);
    rd(2, 1, x, y, oob);
    check("idx1_x", x, 25); check("idx1_y", y, 32);
    rd(0, 2, x, y, oob);
    check("idx2_oob", oob, 1);

    // Saturation and head-pointer wrap
    for (int k = 1; k <= 25; k++) mv(6'(k), 6'(63 - k), 1'b1);
    @(negedge clk);
    check("len_saturated", o_len, MS);
    tick();
    rd(0, 0, x, y, oob);
    check("sat_idx0_x", x, 25); check("sat_idx0_y", y, 38);
    rd(1, 19, x, y, oob);
    check("sat_idx19_x", x, 6); check("sat_idx19_y", y, 57); check("sat_idx19_oob", oob, 0);

    // Move collides with three reads
    rd_idx = '0;
    rd_req = 3'b111;
    mv_req = 1'b1; mv_x = 6'd40; mv_y = 6'd41; mv_grow = 1'b0;
    @(negedge clk);
    check("mv_ack_with_reads", o_mv_ack, 1);
    check("gnt_blocked_by_mv", o_rd_gnt, 0);
    @(posedge clk); #1;
    mv_req = 1'b0;
    pend = 3'b111;
    got  = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) check("gnt_after_mv", o_rd_gnt != 3'b000, 1);
      if (o_rd_vld != 3'b000) begin
        check("new_head_x", o_rd_x, 40);
        check("new_head_y", o_rd_y, 41);
        got++;
      end
      pend = pend & ~o_rd_gnt;
      @(posedge clk); #1;
      rd_req = pend;
    end
    check("reads_after_mv", got, 3);
    rd_req = '0;

    // Clear during a read stream at length 5
    clr = 1'b1; tick(); clr = 1'b0;
    wait_clear("busy_after_clr");
    @(negedge clk);
    check("len_after_clr", o_len, 0);
    tick();
    for (int k = 1; k <= 5; k++) mv(6'(k), 6'(k + 10), 1'b1);
    rd_idx = {5'd4, 5'd2, 5'd0};
    rd_req = 3'b111;
    tick(); tick(); tick();
    clr = 1'b1;
    @(negedge clk);
    check("gnt_on_clr", o_rd_gnt, 0);
    check("vld_in_flight", o_rd_vld != 3'b000, 1);
    @(posedge clk); #1;
    clr = 1'b0;
    n = 0; g = 0;
    @(negedge clk);
    while (o_busy && n < 100) begin
      n++;
      if (o_rd_gnt != 3'b000) g++;
      @(negedge clk);
    end
    check("clr_busy_cycles", n, MS);
    check("gnt_during_clr", g, 0);
    check("len_after_stream_clr", o_len, 0);
    @(posedge clk); #1;
    rd_req = '0;

    // Arbitration order from a fresh pointer
    do_reset();
    rd_idx = '0;
    rd_req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_seq", o_rd_gnt, rr_exp[k]);
      @(posedge clk); #1;
    end
    rd_req = '0;
    tick();

    // Random traffic
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 3; r++) begin
        if (g_prev[r]) pend[r] = 1'b0;
        if (!pend[r] && $urandom_range(0, 9) < 4) begin
          pend[r] = 1'b1;
          rd_idx[r*LW +: LW] = 5'($urandom_range(0, MS + 3));
        end
      end
      rd_req  = pend;
      mv_req  = ($urandom_range(0, 3) == 0);
      mv_grow = $urandom_range(0, 1) == 1;
      mv_x    = 6'($urandom_range(0, 47));
      mv_y    = 6'($urandom_range(0, 63));
      clr     = ($urandom_range(0, 299) == 0);
      tick();
    end
    rd_req = '0; mv_req = 1'b0; clr = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Time limit
  initial begin
    #(2000000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
